// File: rtl/timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// Holds the FSM state encoding and the BCD nibble clamp used on load.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Out-of-range nibbles saturate to 9 so the counter always holds valid BCD.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// Combinational single-digit BCD decrement with borrow chain.
// A digit at 0 receiving a borrow becomes 9 and passes the borrow upward.
module bcd_digit_down
  import timer_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_borrow,
  output logic [3:0] o_digit,
  output logic       o_borrow
);

  always_comb begin
    o_digit  = i_digit;
    o_borrow = 1'b0;
    if (i_borrow) begin
      if (i_digit == 4'd0) begin
        o_digit  = BCD_MAX;
        o_borrow = 1'b1;
      end else begin
        o_digit = i_digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown timer with tick prescaler, run/pause/expire FSM,
// optional auto-reload, warning threshold and one-cycle expiry pulse.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int PRESCALE   = 1,
  parameter int WARN_LEVEL = 5
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    tick_en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    auto_reload,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    warn,
  output logic                    expired,
  output logic                    expire_pulse
);

  localparam int         W          = 4 * NUM_DIGITS;
  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);
  localparam logic [7:0] WARN_BIN   = 8'(WARN_LEVEL);

  state_t         r_state;
  logic [W-1:0]   r_digits;
  logic [W-1:0]   r_reload;
  logic [7:0]     r_presc;
  logic           r_running;
  logic           r_warn;
  logic           r_expired;
  logic           r_pulse;

  state_t         w_state_next;
  logic [W-1:0]   w_digits_next;
  logic [W-1:0]   w_reload_next;
  logic [7:0]     w_presc_next;
  logic           w_pulse_next;
  logic           w_warn_next;

  logic [W-1:0]        w_load_clamped;
  logic [W-1:0]        w_dec;
  logic [NUM_DIGITS:0] w_borrow;
  logic                w_dec_zero;
  logic [7:0]          w_low_bin;
  logic                w_upper_zero;

  assign w_borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_load_clamped[4*gi +: 4] = bcd_clamp(load_value[4*gi +: 4]);
      bcd_digit_down u_digit (
        .i_digit  (r_digits[4*gi +: 4]),
        .i_borrow (w_borrow[gi]),
        .o_digit  (w_dec[4*gi +: 4]),
        .o_borrow (w_borrow[gi+1])
      );
    end
  endgenerate

  // A borrow out of the top digit would mean wrapping past zero; treat it as expiry too.
  assign w_dec_zero = (w_dec == '0) || w_borrow[NUM_DIGITS];

  always_comb begin
    w_state_next  = r_state;
    w_digits_next = r_digits;
    w_reload_next = r_reload;
    w_presc_next  = r_presc;
    w_pulse_next  = 1'b0;
    if (load) begin
      w_digits_next = w_load_clamped;
      w_reload_next = w_load_clamped;
      w_presc_next  = 8'd0;
      w_state_next  = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start && !pause) begin
            if (r_digits == '0) begin
              w_state_next = ST_EXPIRED;
              w_pulse_next = 1'b1;
            end else begin
              w_state_next = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (pause) begin
            w_state_next = ST_PAUSED;
          end else if (tick_en) begin
            if (r_presc == PRESC_LAST) begin
              w_presc_next = 8'd0;
              if (w_dec_zero) begin
                w_pulse_next = 1'b1;
                // A zero reload value would spin at zero, so it expires instead.
                if (auto_reload && (r_reload != '0)) begin
                  w_digits_next = r_reload;
                end else begin
                  w_digits_next = '0;
                  w_state_next  = ST_EXPIRED;
                end
              end else begin
                w_digits_next = w_dec;
              end
            end else begin
              w_presc_next = r_presc + 8'd1;
            end
          end
        end
        ST_PAUSED: begin
          if (start && !pause) w_state_next = ST_RUN;
        end
        ST_EXPIRED: begin
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  generate
    if (NUM_DIGITS >= 2) begin : g_low_two
      assign w_low_bin = 8'(w_digits_next[7:4]) * 8'd10 + 8'(w_digits_next[3:0]);
    end else begin : g_low_one
      assign w_low_bin = 8'(w_digits_next[3:0]);
    end
    if (NUM_DIGITS > 2) begin : g_upper
      assign w_upper_zero = (w_digits_next[W-1:8] == '0);
    end else begin : g_no_upper
      assign w_upper_zero = 1'b1;
    end
  endgenerate

  assign w_warn_next = (w_state_next == ST_RUN) && w_upper_zero &&
                       (w_low_bin <= WARN_BIN) && (w_digits_next != '0);

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_digits  <= '0;
      r_reload  <= '0;
      r_presc   <= 8'd0;
      r_running <= 1'b0;
      r_warn    <= 1'b0;
      r_expired <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_digits  <= w_digits_next;
      r_reload  <= w_reload_next;
      r_presc   <= w_presc_next;
      r_running <= (w_state_next == ST_RUN);
      r_warn    <= w_warn_next;
      r_expired <= (w_state_next == ST_EXPIRED);
      r_pulse   <= w_pulse_next;
    end
  end

  assign digits       = r_digits;
  assign running      = r_running;
  assign warn         = r_warn;
  assign expired      = r_expired;
  assign expire_pulse = r_pulse;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: one PRESCALE=1 and one PRESCALE=4
// instance share stimulus; expected values are hand-derived constants.
module tb_bcd_countdown_timer;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       tick_en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       auto_reload = 1'b0;

  logic [7:0] digits, digits_p4;
  logic       running, warn, expired, expire_pulse;
  logic       running_p4, warn_p4, expired_p4, expire_pulse_p4;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clock = ~clock;

  bcd_countdown_timer #(.NUM_DIGITS(2), .PRESCALE(1), .WARN_LEVEL(5)) u_dut (
    .clock(clock), .rst(rst), .tick_en(tick_en), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .auto_reload(auto_reload), .digits(digits),
    .running(running), .warn(warn), .expired(expired), .expire_pulse(expire_pulse)
  );

  bcd_countdown_timer #(.NUM_DIGITS(2), .PRESCALE(4), .WARN_LEVEL(5)) u_dut_p4 (
    .clock(clock), .rst(rst), .tick_en(tick_en), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .auto_reload(auto_reload), .digits(digits_p4),
    .running(running_p4), .warn(warn_p4), .expired(expired_p4), .expire_pulse(expire_pulse_p4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_tick();
    tick_en = 1'b1; step(); tick_en = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_value = v; step(); load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  logic [7:0] p4_exp [8] = '{8'h05, 8'h05, 8'h05, 8'h04, 8'h04, 8'h04, 8'h04, 8'h03};

  initial begin
    int exp_cnt;
    @(negedge clock);
    // 1: reset
    rst = 1'b1; step(); step(); rst = 1'b0;
    check_eq("rst_digits", 32'(digits), 32'h00);
    check_eq("rst_running", 32'(running), 0);
    check_eq("rst_warn", 32'(warn), 0);
    check_eq("rst_expired", 32'(expired), 0);
    check_eq("rst_pulse", 32'(expire_pulse), 0);

    // 2: count 33 down to 00
    do_load(8'h33);
    check_eq("t2_load", 32'(digits), 32'h33);
    check_eq("t2_idle_running", 32'(running), 0);
    do_start();
    check_eq("t2_running", 32'(running), 1);
    for (int i = 1; i <= 33; i++) begin
      do_tick();
      exp_cnt = 33 - i;
      check_eq($sformatf("t2_cnt_%0d", exp_cnt), 32'(digits), 32'(to_bcd(exp_cnt)));
      check_eq($sformatf("t2_warn_%0d", exp_cnt), 32'(warn),
               32'((exp_cnt != 0) && (exp_cnt <= 5)));
    end
    check_eq("t2_pulse", 32'(expire_pulse), 1);
    check_eq("t2_expired", 32'(expired), 1);
    check_eq("t2_not_running", 32'(running), 0);
    step();
    check_eq("t2_pulse_gone", 32'(expire_pulse), 0);
    do_tick();
    do_start();
    do_tick();
    check_eq("t2_hold_zero", 32'(digits), 32'h00);
    check_eq("t2_still_expired", 32'(expired), 1);

    // 3: borrow across digits, pause/resume
    do_load(8'h10);
    do_start();
    do_tick();
    check_eq("t3_borrow", 32'(digits), 32'h09);
    pause = 1'b1; tick_en = 1'b1; step(); pause = 1'b0; tick_en = 1'b0;
    check_eq("t3_pause_tick", 32'(digits), 32'h09);
    check_eq("t3_paused", 32'(running), 0);
    for (int i = 0; i < 5; i++) do_tick();
    check_eq("t3_paused_hold", 32'(digits), 32'h09);
    do_start();
    do_tick();
    check_eq("t3_resume", 32'(digits), 32'h08);

    // 4: auto-reload
    auto_reload = 1'b1;
    do_load(8'h02);
    do_start();
    do_tick();
    check_eq("t4_first", 32'(digits), 32'h01);
    do_tick();
    check_eq("t4_reload", 32'(digits), 32'h02);
    check_eq("t4_pulse", 32'(expire_pulse), 1);
    check_eq("t4_running", 32'(running), 1);
    check_eq("t4_not_expired", 32'(expired), 0);
    step();
    check_eq("t4_pulse_gone", 32'(expire_pulse), 0);
    auto_reload = 1'b0;

    // 5: prescaler of 4 on the second instance
    do_load(8'h05);
    do_start();
    check_eq("t5_warn_start", 32'(warn_p4), 1);
    for (int i = 0; i < 8; i++) begin
      do_tick();
      check_eq($sformatf("t5_p4_tick%0d", i + 1), 32'(digits_p4), 32'(p4_exp[i]));
      check_eq($sformatf("t5_p4_warn%0d", i + 1), 32'(warn_p4), 1);
    end

    // 6: clamp, load beats reach-zero, reset mid-run, start at zero
    do_load(8'hA7);
    check_eq("t6_clamp", 32'(digits), 32'h97);
    do_load(8'h01);
    do_start();
    tick_en = 1'b1; load = 1'b1; load_value = 8'h42; step();
    tick_en = 1'b0; load = 1'b0;
    check_eq("t6_load_wins", 32'(digits), 32'h42);
    check_eq("t6_no_pulse", 32'(expire_pulse), 0);
    check_eq("t6_idle", 32'(running), 0);
    do_start();
    do_tick();
    check_eq("t6_run", 32'(digits), 32'h41);
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("t6_rst_digits", 32'(digits), 32'h00);
    check_eq("t6_rst_running", 32'(running), 0);
    do_start();
    check_eq("t6_zero_start_exp", 32'(expired), 1);
    check_eq("t6_zero_start_pulse", 32'(expire_pulse), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
